// File: rtl/uart_prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
// State encodings, the default end-of-image marker and a byte-lane merge helper.
package uart_prog_loader_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [31:0] TERM_WORD_DEFAULT = 32'h0000_0FFF;

  function automatic logic [31:0] merge_byte(input logic [31:0] word,
                                             input logic [1:0]  idx,
                                             input logic [7:0]  data);
    logic [31:0] merged;
    merged = word;
    merged[8*idx +: 8] = data;
    return merged;
  endfunction

endpackage

// File: rtl/uart_prog_loader_word_assembler.sv
// Little-endian byte-to-word assembler: 2-bit lane index, 32-bit shift-in register,
// and a combinational word-complete pulse on the 4th accepted byte.
module prog_word_assembler
  import uart_prog_loader_pkg::*;
(
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        clear,
  input  logic        enable,
  input  logic        rx_dv,
  input  logic [7:0]  rx_byte,
  output logic [1:0]  idx,
  output logic [31:0] word_next,
  output logic        word_done
);

  logic [31:0] word_q;
  logic [1:0]  idx_q;
  logic        take;

  assign take      = enable && rx_dv;
  assign word_next = merge_byte(word_q, idx_q, rx_byte);
  assign word_done = take && (idx_q == 2'd3);
  assign idx       = idx_q;

  // Index wraps 3 -> 0, so a byte arriving in the write cycle lands in lane 0.
  always_ff @(posedge i_Clock) begin
    if (i_Reset || clear) begin
      idx_q  <= 2'd0;
      word_q <= 32'd0;
    end else if (take) begin
      word_q <= word_next;
      idx_q  <= idx_q + 2'd1;
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// Boot loader: packs UART bytes into 32-bit words and writes them to program memory.
// Optional partial-word idle timeout is enabled with `define UART_PROG_LOADER_TIMEOUT_EN.
//
//   state     | meaning
//   S_IDLE    | waiting for i_Start, bytes ignored
//   S_COLLECT | armed, gathering bytes of the current word
//   S_WRITE   | memory write in progress, address/count advance
//   S_DONE    | image ended (terminator or abort), Done/Error held
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int          ADDR_W         = 12,
  parameter int          TIMEOUT_CYCLES = 2000000,
  parameter logic [31:0] TERM_WORD      = TERM_WORD_DEFAULT
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_Start,
  input  logic              i_Rx_DV,
  input  logic [7:0]        i_Rx_Byte,
  output logic              o_Mem_We,
  output logic [ADDR_W-1:0] o_Mem_Addr,
  output logic [31:0]       o_Mem_Wdata,
  output logic              o_Busy,
  output logic              o_Done,
  output logic              o_Error,
  output logic [ADDR_W:0]   o_Word_Count
);

  state_t            state_q, state_d;
  logic [1:0]        idx;
  logic [31:0]       word_next;
  logic              word_done;
  logic              is_term;
  logic              accept, start_acc, collect_done;
  logic              write_go, done_set, err_set, tmo_fire;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   count_q;
  logic              ovf_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              done_q, err_q;

  prog_word_assembler u_asm (
    .i_Clock   (i_Clock),
    .i_Reset   (i_Reset),
    .clear     (start_acc | tmo_fire),
    .enable    (accept),
    .rx_dv     (i_Rx_DV),
    .rx_byte   (i_Rx_Byte),
    .idx       (idx),
    .word_next (word_next),
    .word_done (word_done)
  );

  assign is_term = (word_next == TERM_WORD);

`ifdef UART_PROG_LOADER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // Down-counter reloaded by every byte; terminal count after TIMEOUT_CYCLES idle cycles.
  always_ff @(posedge i_Clock) begin
    if (i_Reset || state_q != S_COLLECT || idx == 2'd0 || i_Rx_DV)
      tmo_cnt <= TMO_W'(TIMEOUT_CYCLES);
    else if (tmo_cnt != '0)
      tmo_cnt <= tmo_cnt - TMO_W'(1);
  end

  assign tmo_fire = (state_q == S_COLLECT) && (idx != 2'd0) && !i_Rx_DV &&
                    (tmo_cnt == TMO_W'(1));
`else
  assign tmo_fire = 1'b0;
`endif

  always_ff @(posedge i_Clock) begin
    if (i_Reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Terminator and overflow skip S_WRITE so Done/Error and Busy change together.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (i_Start) state_d = S_COLLECT;
      S_COLLECT: begin
        if (word_done)     state_d = (is_term || ovf_q) ? S_DONE : S_WRITE;
        else if (tmo_fire) state_d = S_DONE;
      end
      S_WRITE:  state_d = S_COLLECT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    accept       = (state_q == S_COLLECT) || (state_q == S_WRITE);
    start_acc    = i_Start && ((state_q == S_IDLE) || (state_q == S_DONE));
    collect_done = (state_q == S_COLLECT) && word_done;
    write_go     = collect_done && !is_term && !ovf_q;
    done_set     = collect_done && is_term;
    err_set      = (collect_done && !is_term && ovf_q) || tmo_fire;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      addr_q      <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mem_we_q <= write_go;
      if (write_go) begin
        mem_addr_q  <= addr_q;
        mem_wdata_q <= word_next;
      end
      if (start_acc) begin
        addr_q  <= '0;
        count_q <= '0;
        ovf_q   <= 1'b0;
        done_q  <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        if (state_q == S_WRITE) begin
          addr_q  <= addr_q + ADDR_W'(1);
          count_q <= count_q + (ADDR_W+1)'(1);
          if (addr_q == '1) ovf_q <= 1'b1;
        end
        if (done_set) done_q <= 1'b1;
        if (err_set)  err_q  <= 1'b1;
      end
    end
  end

  assign o_Mem_We     = mem_we_q;
  assign o_Mem_Addr   = mem_addr_q;
  assign o_Mem_Wdata  = mem_wdata_q;
  assign o_Busy       = accept;
  assign o_Done       = done_q;
  assign o_Error      = err_q;
  assign o_Word_Count = count_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader with a word-level reference model.
// Built with a 4-word memory (ADDR_W=2) so overflow is reachable quickly.
module tb_uart_prog_loader;

  localparam int          ADDR_W = 2;
  localparam int          CW     = ADDR_W + 1;
  localparam int          DEPTH  = 1 << ADDR_W;
  localparam int          TCYC   = 50;
  localparam logic [31:0] TERM   = 32'h0000_0FFF;

  logic              i_Clock = 1'b0;
  logic              i_Reset = 1'b1;
  logic              i_Start = 1'b0;
  logic              i_Rx_DV = 1'b0;
  logic [7:0]        i_Rx_Byte = 8'd0;
  logic              o_Mem_We;
  logic [ADDR_W-1:0] o_Mem_Addr;
  logic [31:0]       o_Mem_Wdata;
  logic              o_Busy, o_Done, o_Error;
  logic [ADDR_W:0]   o_Word_Count;

  typedef struct {int addr; logic [31:0] data;} wr_t;
  wr_t obs_q[$];
  wr_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;
  bit m_armed, m_done, m_err;
  int m_count;

  uart_prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TCYC), .TERM_WORD(TERM)) dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Start(i_Start), .i_Rx_DV(i_Rx_DV),
    .i_Rx_Byte(i_Rx_Byte), .o_Mem_We(o_Mem_We), .o_Mem_Addr(o_Mem_Addr),
    .o_Mem_Wdata(o_Mem_Wdata), .o_Busy(o_Busy), .o_Done(o_Done), .o_Error(o_Error),
    .o_Word_Count(o_Word_Count)
  );

  always #5 i_Clock = ~i_Clock;

  always @(negedge i_Clock)
    if (o_Mem_We === 1'b1) obs_q.push_back('{addr: int'(o_Mem_Addr), data: o_Mem_Wdata});

  task automatic tick();
    @(posedge i_Clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_Rx_DV = 1'b1;
    i_Rx_Byte = b;
    tick();
    i_Rx_DV = 1'b0;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == TERM) w = 32'hCAFE_F00D;
    return w;
  endfunction

  // Reference: address = words written mod depth; a word beyond depth aborts the load.
  task automatic model_word(input logic [31:0] w);
    if (!m_armed) return;
    if (w == TERM) begin
      m_done = 1; m_armed = 0;
    end else if (m_count == DEPTH) begin
      m_err = 1; m_armed = 0;
    end else begin
      exp_q.push_back('{addr: m_count % DEPTH, data: w});
      m_count++;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 0; i < 4; i++) begin
      send_byte(8'((w >> (8 * i)) & 32'hFF));
      if (maxgap > 0 && i < 3) idle($urandom_range(0, maxgap));
    end
    model_word(w);
  endtask

  task automatic do_start();
    obs_q.delete();
    exp_q.delete();
    i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
    m_armed = 1; m_done = 0; m_err = 0; m_count = 0;
  endtask

  task automatic model_reset();
    m_armed = 0; m_done = 0; m_err = 0; m_count = 0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    i_Reset = 1'b1;
    idle(3);
    i_Reset = 1'b0;
    model_reset();
    vectors++;
    if ({o_Mem_We, o_Mem_Addr, o_Mem_Wdata, o_Busy, o_Done, o_Error, o_Word_Count} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got we=%b addr=%0d wd=%h busy=%b done=%b err=%b cnt=%0d expected all 0",
               o_Mem_We, o_Mem_Addr, o_Mem_Wdata, o_Busy, o_Done, o_Error, o_Word_Count);
    end
  endtask

  task automatic test_basic();
    logic [7:0] bytes [12] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                               8'hFF, 8'h0F, 8'h00, 8'h00};
    do_start();
    vectors++;
    if (o_Busy !== 1'b1) begin miscompares++; $display("FAIL start_busy: got %b expected 1", o_Busy); end
    for (int i = 0; i < 4; i++) send_byte(bytes[i]);
    vectors++;
    if ({o_Mem_We, o_Mem_Addr, o_Mem_Wdata, o_Word_Count} !== {1'b1, 2'd0, 32'h1234_5678, 3'd0}) begin
      miscompares++;
      $display("FAIL write_cycle: got we=%b addr=%0d wd=%h cnt=%0d expected 1 0 12345678 0",
               o_Mem_We, o_Mem_Addr, o_Mem_Wdata, o_Word_Count);
    end
    tick();
    vectors++;
    if ({o_Mem_We, o_Word_Count} !== {1'b0, 3'd1}) begin
      miscompares++;
      $display("FAIL count_update: got we=%b cnt=%0d expected 0 1", o_Mem_We, o_Word_Count);
    end
    model_word(32'h1234_5678);
    for (int i = 4; i < 8; i++) send_byte(bytes[i]);
    model_word(32'hDEAD_BEEF);
    idle(2);
    for (int i = 8; i < 12; i++) send_byte(bytes[i]);
    model_word(TERM);
    vectors++;
    if ({o_Done, o_Busy, o_Mem_We} !== 3'b100) begin
      miscompares++;
      $display("FAIL term_edge: got done=%b busy=%b we=%b expected 1 0 0", o_Done, o_Busy, o_Mem_We);
    end
    for (int i = 0; i < 4; i++) send_byte(8'h5A);
    idle(2);
    vectors++;
    if (obs_q.size() !== exp_q.size()) begin
      miscompares++; $display("FAIL basic_nwrites: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
        miscompares++;
        $display("FAIL basic_write%0d: got %0d:%h expected %0d:%h", i, obs_q[i].addr, obs_q[i].data,
                 exp_q[i].addr, exp_q[i].data);
      end
    end
    vectors++;
    if ({o_Done, o_Error, o_Busy, o_Word_Count} !== {m_done, m_err, m_armed, CW'(m_count)}) begin
      miscompares++;
      $display("FAIL basic_status: got done=%b err=%b busy=%b cnt=%0d expected %b %b %b %0d",
               o_Done, o_Error, o_Busy, o_Word_Count, m_done, m_err, m_armed, m_count);
    end
  endtask

  task automatic test_overflow();
    do_start();
    for (int k = 0; k < 6; k++) send_word(rand_word(), 0);
    idle(2);
    vectors++;
    if (obs_q.size() !== exp_q.size()) begin
      miscompares++; $display("FAIL ovf_nwrites: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
        miscompares++;
        $display("FAIL ovf_write%0d: got %0d:%h expected %0d:%h", i, obs_q[i].addr, obs_q[i].data,
                 exp_q[i].addr, exp_q[i].data);
      end
    end
    vectors++;
    if ({o_Done, o_Error, o_Busy, o_Word_Count} !== {1'b0, 1'b1, 1'b0, 3'd4}) begin
      miscompares++;
      $display("FAIL ovf_status: got done=%b err=%b busy=%b cnt=%0d expected 0 1 0 4",
               o_Done, o_Error, o_Busy, o_Word_Count);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w1;
    w1 = rand_word();
    do_start();
    send_word(w1, 0);
    send_word(32'hDDCC_BBAA, 0);
    send_word(TERM, 0);
    idle(2);
    vectors++;
    if (obs_q.size() != 2 || obs_q[1].addr !== 1 || obs_q[1].data !== 32'hDDCC_BBAA) begin
      miscompares++;
      $display("FAIL b2b_second: got n=%0d last=%h expected 2 writes, ddccbbaa @1", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[obs_q.size()-1].data : 32'h0);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
        miscompares++;
        $display("FAIL b2b_write%0d: got %0d:%h expected %0d:%h", i, obs_q[i].addr, obs_q[i].data,
                 exp_q[i].addr, exp_q[i].data);
      end
    end
  endtask

  task automatic test_reset_midword();
    logic [31:0] w;
    w = rand_word();
    do_start();
    send_byte(8'h11);
    send_byte(8'h22);
    i_Reset = 1'b1;
    tick();
    vectors++;
    if ({o_Mem_We, o_Busy, o_Word_Count} !== '0) begin
      miscompares++;
      $display("FAIL reset_abort: got we=%b busy=%b cnt=%0d expected 0 0 0", o_Mem_We, o_Busy, o_Word_Count);
    end
    i_Reset = 1'b0;
    model_reset();
    do_start();
    send_word(w, 2);
    send_word(TERM, 0);
    idle(2);
    vectors++;
    if (obs_q.size() != 1 || exp_q.size() != 1 || obs_q[0].addr !== exp_q[0].addr ||
        obs_q[0].data !== exp_q[0].data) begin
      miscompares++;
      $display("FAIL reset_rewrite: got n=%0d first=%h expected 1 write %h @0", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0].data : 32'h0, w);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
    do_start();
    send_byte(b[0]);
    idle(TCYC + 2);
`ifdef UART_PROG_LOADER_TIMEOUT_EN
    m_err = 1; m_armed = 0;
`else
    for (int i = 1; i < 4; i++) send_byte(b[i]);
    model_word({b[3], b[2], b[1], b[0]});
    idle(2);
`endif
    vectors++;
    if (obs_q.size() !== exp_q.size()) begin
      miscompares++; $display("FAIL tmo_nwrites: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
        miscompares++;
        $display("FAIL tmo_write%0d: got %0d:%h expected %0d:%h", i, obs_q[i].addr, obs_q[i].data,
                 exp_q[i].addr, exp_q[i].data);
      end
    end
    vectors++;
    if ({o_Error, o_Busy, o_Word_Count} !== {m_err, m_armed, CW'(m_count)}) begin
      miscompares++;
      $display("FAIL tmo_status: got err=%b busy=%b cnt=%0d expected %b %b %0d",
               o_Error, o_Busy, o_Word_Count, m_err, m_armed, m_count);
    end
  endtask

  task automatic test_ignore();
    logic [31:0] w;
    w = rand_word();
    i_Reset = 1'b1;
    idle(2);
    i_Reset = 1'b0;
    model_reset();
    send_word(rand_word(), 1);
    idle(2);
    vectors++;
    if (obs_q.size() != 0 || o_Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_dv: got n=%0d busy=%b expected 0 0", obs_q.size(), o_Busy);
    end
    do_start();
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
    send_byte(w[23:16]);
    send_byte(w[31:24]);
    model_word(w);
    send_word(TERM, 0);
    idle(2);
    vectors++;
    if (obs_q.size() != 1 || obs_q[0].addr !== 0 || obs_q[0].data !== w) begin
      miscompares++;
      $display("FAIL midword_start: got n=%0d first=%h expected 1 write %h @0", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0].data : 32'h0, w);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      do_start();
      for (int k = $urandom_range(0, 5); k > 0; k--) begin
        send_word(rand_word(), 3);
        idle($urandom_range(0, 2));
      end
      send_word(TERM, 2);
      idle(2);
      vectors++;
      if (obs_q.size() !== exp_q.size()) begin
        miscompares++; $display("FAIL rand%0d_nwrites: got %0d expected %0d", it, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        vectors++;
        if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
          miscompares++;
          $display("FAIL rand%0d_write%0d: got %0d:%h expected %0d:%h", it, i, obs_q[i].addr,
                   obs_q[i].data, exp_q[i].addr, exp_q[i].data);
        end
      end
      vectors++;
      if ({o_Done, o_Error, o_Busy, o_Word_Count} !== {m_done, m_err, m_armed, CW'(m_count)}) begin
        miscompares++;
        $display("FAIL rand%0d_status: got done=%b err=%b busy=%b cnt=%0d expected %b %b %b %0d", it,
                 o_Done, o_Error, o_Busy, o_Word_Count, m_done, m_err, m_armed, m_count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_reset_midword();
    test_timeout();
    test_ignore();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

- Consumes the byte stream from the UART receiver (`o_Rx_DV` / `o_Rx_Byte`).
- Assembles bytes little-endian into 32-bit words and writes them to program memory through a single-cycle write port at sequential word addresses.
- Sits between the UART receiver and the instruction-memory write mux; it is used to boot-load a program image over serial.

## Interface
Parameters:
- `ADDR_W`, 12: word-address width of program memory.
- `TIMEOUT_CYCLES`, 2000000: idle-gap limit inside a partial word. Used only with the timeout feature.
- `TERM_WORD`, 32'h0000_0FFF: end-of-image marker. This word is not written.

Ports:
- `i_Clock`, in, 1: single clock; everything is synchronous to its rising edge.
- `i_Reset`, in, 1: reset, synchronous, active-high.
- `i_Start`, in, 1: one-cycle pulse that arms the loader.
- `i_Rx_DV`, in, 1: byte-valid strobe from the UART receiver, one cycle per byte.
- `i_Rx_Byte`, in, 8: received byte, valid while `i_Rx_DV` is high.
- `o_Mem_We`, out, 1: memory write strobe, one cycle per word.
- `o_Mem_Addr`, out, ADDR_W: word address, valid while `o_Mem_We` is high.
- `o_Mem_Wdata`, out, 32: write data, valid while `o_Mem_We` is high.
- `o_Busy`, out, 1: loader is armed or receiving.
- `o_Done`, out, 1: sticky; the image completed with the terminator.
- `o_Error`, out, 1: sticky; the load was aborted by overflow or timeout.
- `o_Word_Count`, out, ADDR_W+1: number of words written in the current load.

## Operation
States:
- **S_IDLE**
  - `i_Start` → S_COLLECT.
  - On that transition: byte index, address, word count, Done and Error are all cleared.
  - `i_Rx_DV` is ignored.
- **S_COLLECT**
  - Each `i_Rx_DV` stores `i_Rx_Byte` into word bits [8*idx+7:8*idx]; idx is 2 bits and starts at 0.
  - On the 4th byte (idx = 3), go to S_WRITE with the full word registered.
- **S_WRITE** (one cycle)
  - If word == `TERM_WORD`: no write; assert Done; → S_DONE.
  - Else, if this is the write after address 2^ADDR_W−1 has already been written (overflow): no write; assert Error; → S_DONE.
  - Else: `o_Mem_We` = 1 with the current address and word; address +1 (wraps to 0 in width); word count +1; → S_COLLECT.
  - If `i_Rx_DV` is high in this cycle, the byte is captured as byte 0 of the next word, and idx becomes 1.
- **S_DONE**
  - Holds Done/Error.
  - `i_Start` → S_COLLECT, with the same clears as from S_IDLE.
  - `i_Rx_DV` is ignored.

Other rules:
- `i_Start` in S_COLLECT or S_WRITE is ignored.
- `o_Busy` = 1 in S_COLLECT and S_WRITE.
- Overflow is tracked with a 1-bit flag, set when address 2^ADDR_W−1 is written.
- Bytes after the terminator are ignored until the next `i_Start`.

## Timing
- Reset values: all outputs 0; state S_IDLE; address, idx and count all 0.
- Reset has priority over every other event and aborts mid-word or mid-write.
  - `o_Mem_We` is 0 on the cycle after reset is asserted.
- `i_Start` at cycle N: `o_Busy` = 1 at N+1.
- 4th `i_Rx_DV` at cycle N: `o_Mem_We` = 1 during N+1 only, and `o_Word_Count` is updated at N+2.
- `o_Done` or `o_Error` rises at N+1 relative to the terminating or offending 4th byte. `o_Busy` falls in the same cycle.
- `o_Mem_Addr` and `o_Mem_Wdata` are registered. They are don't-care when `o_Mem_We` = 0, but must hold the last values (no glitching).
- There is no back-pressure: memory accepts a write every cycle.

## Configuration
- `UART_PROG_LOADER_TIMEOUT_EN` defined:
  - A counter runs while in S_COLLECT with idx ≠ 0; it is cleared on every `i_Rx_DV`.
  - When it reaches `TIMEOUT_CYCLES`, the partial word is discarded, Error is set, and the state goes to S_DONE.
  - The counter width is $clog2(TIMEOUT_CYCLES+1).
- Undefined:
  - No counter exists.
  - A partial word waits indefinitely.
  - `TIMEOUT_CYCLES` is unused.

## Structure
- Shared package holds:
  - state encodings S_IDLE=2'd0, S_COLLECT=2'd1, S_WRITE=2'd2, S_DONE=2'd3;
  - the default `TERM_WORD` constant.
- One sub-module: `prog_word_assembler`, covering the byte-index counter, shift-in into the 32-bit register, and the word-complete pulse. The FSM, address and count logic stay in the top module.

## Test plan
1. Start, then bytes 78 56 34 12 EF BE AD DE FF 0F 00 00 → writes 0x12345678 @0 and 0xDEADBEEF @1; Done=1; Word_Count=2; Error=0.
2. ADDR_W=2, six non-terminator words → four writes at addresses 0..3; 5th word gives no write and Error=1; 6th word is ignored; Word_Count=4.
3. `i_Rx_DV` coincident with the `o_Mem_We` cycle (byte AA), then bytes BB CC DD → next write data 0xDDCCBBAA at the next address.
4. Reset pulsed after 2 bytes, then Start and 4 new bytes → the write contains only the new bytes, at address 0.
5. With `UART_PROG_LOADER_TIMEOUT_EN` and TIMEOUT_CYCLES=50: 1 byte, then 50 idle cycles → Error=1 and no write. Without the macro: no Error, and a later 3 bytes complete the word.
6. `i_Rx_DV` before Start and `i_Start` mid-word → both ignored; no writes and no index change.
